// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned divider by repeated subtraction.
// A start pulse in IDLE captures dividend/divisor. CALC then subtracts the
// divisor once per cycle until the running remainder drops below it. DONE
// raises a one-cycle done pulse. quotient/remainder are written only when a
// result completes.
// Optional build macro: DIV_ZERO_ERR_EN adds an err output flagging divide-by-zero.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Divisor of zero short-circuits the loop and produces the saturated result.
  function automatic logic is_zero(input logic [WIDTH-1:0] value);
    return (value == ZERO_W);
  endfunction

  // Another subtraction is possible while the remainder is at least the divisor.
  function automatic logic can_subtract(input logic [WIDTH-1:0] rem_val,
                                        input logic [WIDTH-1:0] dsr_val);
    return (rem_val >= dsr_val);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIV_ZERO_ERR_EN
  logic             err_q, err_d;
`endif

  // Next-state, datapath, and result update for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    q_d         = q_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_ERR_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = dividend;
          dsr_d   = divisor;
          q_d     = ZERO_W;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (is_zero(dsr_q)) begin
          quotient_d  = ONES_W;
          remainder_d = rem_q;
          state_d     = ST_DONE;
`ifdef DIV_ZERO_ERR_EN
          err_d       = 1'b1;
`endif
        end else if (can_subtract(rem_q, dsr_q)) begin
          // q never exceeds the dividend, so this increment cannot wrap.
          rem_d   = rem_q - dsr_q;
          q_d     = q_q + ONE_W;
          state_d = ST_CALC;
        end else begin
          quotient_d  = q_q;
          remainder_d = rem_q;
          state_d     = ST_DONE;
`ifdef DIV_ZERO_ERR_EN
          err_d       = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy/done are decoded from the next state, so their flops always track
  // the registered state.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      ST_CALC: begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers. clr overrides everything, including an
  // operation in progress.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      rem_q       <= ZERO_W;
      dsr_q       <= ZERO_W;
      q_q         <= ZERO_W;
      quotient_q  <= ZERO_W;
      remainder_q <= ZERO_W;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      q_q         <= q_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_ZERO_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DIV_ZERO_ERR_EN
  assign err       = err_q;
`endif

endmodule
